conv_row_feeder: RTL
====================

CONV_ROW_FEEDER -- requirements
Module: conv_row_feeder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IN_WIDTH, 5, pixel width.
- W_WIDTH, 8, weight width.
- ACC_WIDTH, 15, array partial-sum width.
- TIMEOUT, 64, max cycles to wait for arr_finished.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock.
- rst in 1: asynchronous active-low reset.
- px_valid in 1, px_ready out 1, px_data in IN_WIDTH: pixel stream.
- wt_valid in 1, wt_ready out 1, wt_data in W_WIDTH: weight stream.
- arr_start out 1: one-cycle start pulse to the PE array.
- arr_in_data out 5*IN_WIDTH: one tile row, pixel k at bits [k*IN_WIDTH +: IN_WIDTH].
- arr_in_filter out 3*W_WIDTH: one filter row, weight k at [k*W_WIDTH +: W_WIDTH].
- arr_out_data in 3*ACC_WIDTH: three signed partials from the array.
- arr_finished in 1: array done.
- res_valid out 1, res_ready in 1, res_data out ACC_WIDTH+2, res_last out 1: result stream.
- busy out 1: not IDLE.
- err out 1: sticky timeout flag.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, START, WAIT, EMIT.
REQ-004 IDLE SHALL go to LOAD when px_valid or wt_valid is high.
REQ-005 LOAD behaviour:
- Accepts 15 pixels (row-major 3x5 tile) and 9 weights (row-major 3x3) concurrently.
- px_ready is high while pixel count < 15; wt_ready is high while weight count < 9.
- A beat transfers on valid&&ready.
REQ-006 LOAD SHALL go to START in the cycle after both counts are complete; simultaneous final beats on both streams SHALL both be accepted.
REQ-007 START and WAIT SHALL run passes p = 0, 1, 2.
- START asserts arr_start for exactly one cycle.
- arr_in_data and arr_in_filter hold tile row p and filter row p from START until arr_finished is sampled.
REQ-008 On arr_finished in WAIT:
- Each of the three partials SHALL be sign-extended to ACC_WIDTH+2 and added to accumulator j.
- p < 2: go to START with p+1.
- p = 2: go to EMIT.
REQ-009 Accumulators SHALL be cleared on entry to pass 0; the sum SHALL be full-width with no overflow possible.
REQ-010 WAIT timeout:
- A cycle counter runs in WAIT; reaching TIMEOUT without arr_finished sets err, discards the tile and returns to IDLE.
- err clears only on reset.
REQ-011 EMIT SHALL present accumulators 0, 1, 2 in order.
- res_valid is high throughout.
- Data is held stable while res_ready is low.
- res_last is high on beat 2 only.
- Go to IDLE after beat 2 transfers.
REQ-012 arr_finished outside WAIT SHALL be ignored.
REQ-013 Latency: after the last load beat, arr_start SHALL rise one cycle later, and res_valid SHALL rise one cycle after the pass-2 arr_finished.
REQ-014 px_ready and wt_ready SHALL be low in all states except LOAD.

Reset
REQ-015 While rst is low, the block SHALL enter IDLE and clear all counters, accumulators and err; px_ready, wt_ready, arr_start, res_valid, res_last, busy, err, arr_in_data, arr_in_filter and res_data SHALL be 0.
REQ-016 Reset asserted mid-LOAD, WAIT or EMIT SHALL abandon the operation immediately with no further arr_start or res_valid.

Structure
REQ-017 A shared package SHALL hold the FSM state encoding, tile constants (TILE_ROWS=3, TILE_COLS=5, FILT_TAPS=3) and the width defaults.
REQ-018 The tile and filter buffer with load counters SHALL be one sub-module, conv_tile_buffer; the FSM and accumulators SHALL stay in the top.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Nominal: pixels all 1, weights all 1, array model returning partial = 3 per lane after a 4-cycle delay -> results 9, 9, 9; res_last on the third beat; exactly three arr_start pulses.
- Signed: array model returns -5, 0, 16383 on each pass -> results -15, 0, 49149 at ACC_WIDTH+2 width.
- Skewed load: all 9 weights sent first, then 15 pixels with a bubble every other cycle -> wt_ready drops after beat 9 and arr_start rises one cycle after the 15th pixel.
- Backpressure: res_ready low for 5 cycles at beat 1 -> res_data is held, no beat is lost or duplicated.
- Timeout: arr_finished never asserted -> err=1 after 64 WAIT cycles, busy=0, then the next tile completes normally with err still 1.
- Reset mid-WAIT: rst low for 2 cycles during pass 1 -> all outputs 0, no res_valid, and the next tile gives correct results.

Source files
------------

// File: rtl/conv_row_feeder_pkg.sv
// conv_row_feeder_pkg
// Shared definitions for the convolution row feeder: FSM state encoding,
// tile geometry and default widths used by conv_row_feeder and
// conv_tile_buffer.
package conv_row_feeder_pkg;

    localparam int TILE_ROWS = 3;
    localparam int TILE_COLS = 5;
    localparam int FILT_TAPS = 3;
    localparam int PX_TOTAL  = TILE_ROWS * TILE_COLS;
    localparam int WT_TOTAL  = TILE_ROWS * FILT_TAPS;

    localparam int IN_WIDTH_DEF  = 5;
    localparam int W_WIDTH_DEF   = 8;
    localparam int ACC_WIDTH_DEF = 15;
    localparam int TIMEOUT_DEF   = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4
    } state_e;

endpackage

// File: rtl/conv_tile_buffer.sv
// conv_tile_buffer
// Holds one 3x5 pixel tile and one 3x3 filter, filled row-major from two
// independent valid/ready streams, and muxes out one row of each.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   load_en_i          owner is in its load phase; enables the ready outputs
//   clear_i            zero both load counters (tile discarded)
//   px_valid_i/px_data_i/px_ready_o   pixel stream
//   wt_valid_i/wt_data_i/wt_ready_o   weight stream
//   load_done_o        both counts complete once this cycle's beats land
//   row_sel_i          tile/filter row to present (0..2)
//   row_data_o         pixel k of the row at [k*IN_WIDTH +: IN_WIDTH]
//   row_filt_o         weight k of the row at [k*W_WIDTH +: W_WIDTH]
module conv_tile_buffer
    import conv_row_feeder_pkg::*;
#(
    parameter int IN_WIDTH = IN_WIDTH_DEF,
    parameter int W_WIDTH  = W_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_en_i,
    input  logic                           clear_i,
    input  logic                           px_valid_i,
    input  logic [IN_WIDTH-1:0]            px_data_i,
    output logic                           px_ready_o,
    input  logic                           wt_valid_i,
    input  logic [W_WIDTH-1:0]             wt_data_i,
    output logic                           wt_ready_o,
    output logic                           load_done_o,
    input  logic [1:0]                     row_sel_i,
    output logic [TILE_COLS*IN_WIDTH-1:0]  row_data_o,
    output logic [FILT_TAPS*W_WIDTH-1:0]   row_filt_o
);

    localparam int PXC_W = $clog2(PX_TOTAL + 1);
    localparam int WTC_W = $clog2(WT_TOTAL + 1);

    logic [PXC_W-1:0]    px_cnt_q, px_cnt_d;
    logic [WTC_W-1:0]    wt_cnt_q, wt_cnt_d;
    logic                px_fire, wt_fire;
    logic [IN_WIDTH-1:0] px_mem_q [PX_TOTAL];
    logic [W_WIDTH-1:0]  wt_mem_q [WT_TOTAL];

    assign px_ready_o = load_en_i && (px_cnt_q < PXC_W'(PX_TOTAL));
    assign wt_ready_o = load_en_i && (wt_cnt_q < WTC_W'(WT_TOTAL));
    assign px_fire    = px_valid_i && px_ready_o;
    assign wt_fire    = wt_valid_i && wt_ready_o;

    always_comb begin
        px_cnt_d = px_cnt_q;
        wt_cnt_d = wt_cnt_q;
        if (clear_i) begin
            px_cnt_d = '0;
            wt_cnt_d = '0;
        end else begin
            if (px_fire) px_cnt_d = px_cnt_q + 1'b1;
            if (wt_fire) wt_cnt_d = wt_cnt_q + 1'b1;
        end
    end

    // Looks at the post-beat counts so the owner can leave load on the same
    // edge that accepts the final beat(s), including simultaneous ones.
    assign load_done_o = load_en_i && (px_cnt_d == PXC_W'(PX_TOTAL))
                                   && (wt_cnt_d == WTC_W'(WT_TOTAL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_cnt_q <= '0;
            wt_cnt_q <= '0;
        end else begin
            px_cnt_q <= px_cnt_d;
            wt_cnt_q <= wt_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (px_fire) px_mem_q[px_cnt_q] <= px_data_i;
        if (wt_fire) wt_mem_q[wt_cnt_q] <= wt_data_i;
    end

    always_comb begin
        row_data_o = '0;
        row_filt_o = '0;
        for (int k = 0; k < TILE_COLS; k++) begin
            case (row_sel_i)
                2'd0:    row_data_o[k*IN_WIDTH +: IN_WIDTH] = px_mem_q[k];
                2'd1:    row_data_o[k*IN_WIDTH +: IN_WIDTH] = px_mem_q[TILE_COLS + k];
                2'd2:    row_data_o[k*IN_WIDTH +: IN_WIDTH] = px_mem_q[2*TILE_COLS + k];
                default: row_data_o[k*IN_WIDTH +: IN_WIDTH] = '0;
            endcase
        end
        for (int k = 0; k < FILT_TAPS; k++) begin
            case (row_sel_i)
                2'd0:    row_filt_o[k*W_WIDTH +: W_WIDTH] = wt_mem_q[k];
                2'd1:    row_filt_o[k*W_WIDTH +: W_WIDTH] = wt_mem_q[FILT_TAPS + k];
                2'd2:    row_filt_o[k*W_WIDTH +: W_WIDTH] = wt_mem_q[2*FILT_TAPS + k];
                default: row_filt_o[k*W_WIDTH +: W_WIDTH] = '0;
            endcase
        end
    end

endmodule

// File: rtl/conv_row_feeder.sv
// conv_row_feeder
// Loads a 3x5 pixel tile and a 3x3 filter, drives the PE array with one
// tile row / filter row per pass (three passes), accumulates the three
// signed partials of each pass and streams the three sums out.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   px_valid/px_ready/px_data      pixel stream in
//   wt_valid/wt_ready/wt_data      weight stream in
//   arr_start                      one-cycle start pulse per pass
//   arr_in_data, arr_in_filter     current tile row / filter row
//   arr_out_data, arr_finished     three partials and done from the array
//   res_valid/res_ready/res_data/res_last   result stream out (3 beats)
//   busy                           FSM not idle
//   err                            sticky array timeout flag
//
// state  | meaning
// IDLE   | waiting for either input stream to become valid
// LOAD   | accepting 15 pixels and 9 weights
// START  | arr_start pulse for pass p
// WAIT   | waiting for arr_finished, timeout counter running
// EMIT   | presenting accumulators 0,1,2 on the result stream
module conv_row_feeder
    import conv_row_feeder_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           px_valid,
    output logic                           px_ready,
    input  logic [IN_WIDTH-1:0]            px_data,
    input  logic                           wt_valid,
    output logic                           wt_ready,
    input  logic [W_WIDTH-1:0]             wt_data,
    output logic                           arr_start,
    output logic [TILE_COLS*IN_WIDTH-1:0]  arr_in_data,
    output logic [FILT_TAPS*W_WIDTH-1:0]   arr_in_filter,
    input  logic [FILT_TAPS*ACC_WIDTH-1:0] arr_out_data,
    input  logic                           arr_finished,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ACC_WIDTH+1:0]           res_data,
    output logic                           res_last,
    output logic                           busy,
    output logic                           err
);

    localparam int RES_W = ACC_WIDTH + 2;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e                          state_q;
    logic [1:0]                      pass_q;
    logic [1:0]                      beat_q;
    logic [TMO_W-1:0]                tmo_q;
    logic signed [RES_W-1:0]         acc_q   [FILT_TAPS];
    logic signed [RES_W-1:0]         acc_sum [FILT_TAPS];
    logic signed [ACC_WIDTH-1:0]     part    [FILT_TAPS];
    logic signed [RES_W-1:0]         emit_next;
    logic                            arr_start_q, res_valid_q, res_last_q, err_q;
    logic [RES_W-1:0]                res_data_q;
    logic [TILE_COLS*IN_WIDTH-1:0]   arr_in_data_q;
    logic [FILT_TAPS*W_WIDTH-1:0]    arr_in_filter_q;

    logic                            load_done;
    logic [1:0]                      row_sel;
    logic [TILE_COLS*IN_WIDTH-1:0]   row_data;
    logic [FILT_TAPS*W_WIDTH-1:0]    row_filt;

    // Row for the pass about to start: row 0 out of LOAD, p+1 out of WAIT.
    assign row_sel = (state_q == ST_WAIT) ? pass_q + 2'd1 : 2'd0;

    conv_tile_buffer #(
        .IN_WIDTH (IN_WIDTH),
        .W_WIDTH  (W_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_en_i   (state_q == ST_LOAD),
        .clear_i     (state_q == ST_IDLE),
        .px_valid_i  (px_valid),
        .px_data_i   (px_data),
        .px_ready_o  (px_ready),
        .wt_valid_i  (wt_valid),
        .wt_data_i   (wt_data),
        .wt_ready_o  (wt_ready),
        .load_done_o (load_done),
        .row_sel_i   (row_sel),
        .row_data_o  (row_data),
        .row_filt_o  (row_filt)
    );

    // Partials are sign-extended two bits; three additions cannot overflow.
    always_comb begin
        for (int j = 0; j < FILT_TAPS; j++) begin
            part[j]    = arr_out_data[j*ACC_WIDTH +: ACC_WIDTH];
            acc_sum[j] = acc_q[j] + RES_W'(part[j]);
        end
    end

    assign emit_next = (beat_q == 2'd0) ? acc_q[1] : acc_q[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            pass_q          <= '0;
            beat_q          <= '0;
            tmo_q           <= '0;
            arr_start_q     <= 1'b0;
            res_valid_q     <= 1'b0;
            res_last_q      <= 1'b0;
            res_data_q      <= '0;
            err_q           <= 1'b0;
            arr_in_data_q   <= '0;
            arr_in_filter_q <= '0;
            for (int j = 0; j < FILT_TAPS; j++) acc_q[j] <= '0;
        end else begin
            arr_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (px_valid || wt_valid) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (load_done) begin
                        state_q         <= ST_START;
                        pass_q          <= 2'd0;
                        arr_start_q     <= 1'b1;
                        arr_in_data_q   <= row_data;
                        arr_in_filter_q <= row_filt;
                        for (int j = 0; j < FILT_TAPS; j++) acc_q[j] <= '0;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    tmo_q   <= TMO_W'(TIMEOUT - 1);
                end
                ST_WAIT: begin
                    if (arr_finished) begin
                        for (int j = 0; j < FILT_TAPS; j++) acc_q[j] <= acc_sum[j];
                        if (pass_q == 2'd2) begin
                            state_q     <= ST_EMIT;
                            beat_q      <= 2'd0;
                            res_valid_q <= 1'b1;
                            res_last_q  <= 1'b0;
                            res_data_q  <= acc_sum[0];
                        end else begin
                            state_q         <= ST_START;
                            pass_q          <= pass_q + 2'd1;
                            arr_start_q     <= 1'b1;
                            arr_in_data_q   <= row_data;
                            arr_in_filter_q <= row_filt;
                        end
                    end else if (tmo_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        if (beat_q == 2'd2) begin
                            state_q     <= ST_IDLE;
                            res_valid_q <= 1'b0;
                            res_last_q  <= 1'b0;
                            res_data_q  <= '0;
                        end else begin
                            beat_q     <= beat_q + 2'd1;
                            res_data_q <= emit_next;
                            res_last_q <= (beat_q == 2'd1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign arr_start     = arr_start_q;
    assign arr_in_data   = arr_in_data_q;
    assign arr_in_filter = arr_in_filter_q;
    assign res_valid     = res_valid_q;
    assign res_last      = res_last_q;
    assign res_data      = res_data_q;
    assign err           = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
